// File: rtl/int_pkg.sv
// Shared interrupt definitions: default widths, vector stride and the dispatcher state set.
// Also imported by the interrupt controller so both sides agree on id width.
package int_pkg;

    localparam int ID_W_DEF      = 8;
    localparam int ADDR_W_DEF    = 32;
    localparam int VEC_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        JUMP    = 3'd2,
        SERVICE = 3'd3,
        RETURN  = 3'd4
    } int_state_e;

endpackage : int_pkg

// File: rtl/int_dispatch_if.sv
// Bundle between the dispatcher, the interrupt controller, the core and the vector-fetch port.
// master = the surrounding system (controller/core/memory), slave = the dispatcher.
interface int_dispatch_if #(
    parameter int ID_W   = int_pkg::ID_W_DEF,
    parameter int ADDR_W = int_pkg::ADDR_W_DEF
);
    logic              gie;
    logic              available;
    logic [ID_W-1:0]   dev_id;
    logic              ic_enable;
    logic              boundary;
    logic [ADDR_W-1:0] cur_pc;
    logic [ADDR_W-1:0] vec_base;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rdata;
    logic              take;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_pc;
    logic              ack;
    logic [ID_W-1:0]   ack_id;
    logic              in_service;
    logic              iret;

    modport master (
        output gie, available, dev_id, boundary, cur_pc, vec_base,
               mem_ready, mem_rdata, iret,
        input  ic_enable, mem_req, mem_addr, take, jump_valid, jump_pc,
               ack, ack_id, in_service
    );

    modport slave (
        input  gie, available, dev_id, boundary, cur_pc, vec_base,
               mem_ready, mem_rdata, iret,
        output ic_enable, mem_req, mem_addr, take, jump_valid, jump_pc,
               ack, ack_id, in_service
    );

endinterface : int_dispatch_if

// File: rtl/int_dispatch.sv
// CPU-side interrupt dispatcher: accepts at an instruction boundary, fetches the vector,
// redirects the core, acknowledges the source and blocks nesting until return-from-interrupt.
module int_dispatch
    import int_pkg::*;
#(
    parameter int ID_W      = ID_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    int_dispatch_if.slave  bus_if
);

    int_state_e        state_q, state_d;
    logic [ID_W-1:0]   cur_id_q;
    logic [ID_W-1:0]   ack_id_q;
    logic [ADDR_W-1:0] epc_q;
    logic [ADDR_W-1:0] handler_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] jump_pc_q;
    logic              take_q;
    logic              accept;
    logic              fetch_done;
    logic              ret_go;

    function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ID_W-1:0]   id);
        return base + (ADDR_W'(id) << VEC_SHIFT);
    endfunction

    // rst_n gates the enable so the controller sees 0 throughout reset, not just the state.
    assign bus_if.ic_enable = rst_n && bus_if.gie && (state_q == IDLE);
    assign accept     = bus_if.ic_enable && bus_if.available && bus_if.boundary;
    assign fetch_done = (state_q == FETCH) && bus_if.mem_ready;
    assign ret_go     = (state_q == SERVICE) && bus_if.iret;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)           state_d = FETCH;
            FETCH:   if (bus_if.mem_ready) state_d = JUMP;
            JUMP:                          state_d = SERVICE;
            SERVICE: if (bus_if.iret)      state_d = RETURN;
            RETURN:                        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // The fetch address is frozen at accept so later dev_id/vec_base activity cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_id_q   <= '0;
            ack_id_q   <= '0;
            epc_q      <= '0;
            handler_q  <= '0;
            mem_addr_q <= '0;
            jump_pc_q  <= '0;
            take_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            take_q  <= accept;
            if (accept) begin
                cur_id_q   <= bus_if.dev_id;
                epc_q      <= bus_if.cur_pc;
                mem_addr_q <= vec_addr(bus_if.vec_base, bus_if.dev_id);
            end
            if (fetch_done) begin
                handler_q <= bus_if.mem_rdata;
                ack_id_q  <= cur_id_q;
            end
            if (state_q == JUMP) begin
                jump_pc_q <= handler_q;
            end
            if (ret_go) begin
                jump_pc_q <= epc_q;
            end
        end
    end

    assign bus_if.mem_req    = (state_q == FETCH);
    assign bus_if.mem_addr   = mem_addr_q;
    assign bus_if.take       = take_q;
    assign bus_if.jump_valid = (state_q == JUMP) || (state_q == RETURN);
    assign bus_if.jump_pc    = (state_q == JUMP) ? handler_q : jump_pc_q;
    assign bus_if.ack        = (state_q == JUMP);
    assign bus_if.ack_id     = ack_id_q;
    assign bus_if.in_service = (state_q == SERVICE);

endmodule : int_dispatch
